// File: rtl/fifo_ptr_ctrl_pkg.sv
// rtl/fifo_ptr_ctrl_pkg.sv - shared FIFO sizing and memory-controller constants
package fifo_ptr_ctrl_pkg;
   localparam int FIFO_WIDTH    = 3;
   localparam int FIFO_DEPTH    = 2 ** FIFO_WIDTH;
   localparam int FIFO_DATA_W   = 32;
   // Address bit that steers a request to SRAM bank 0 or bank 1.
   localparam int MC_BANK_BIT   = 0;
   localparam int MC_NUM_BANKS  = 2;
   localparam int MC_RD_LATENCY = 1;
endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping FIFO pointer with one extra lap bit
module fifo_ptr #(
   parameter int WIDTH = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic [WIDTH:0] ptr
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (en)
         ptr <= ptr + 1'b1;
   end
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointer control in front of a two-bank SRAM memory controller
module fifo_ptr_ctrl
   import fifo_ptr_ctrl_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [FIFO_DATA_W-1:0] push_data,
   input  logic                   pop,
   output logic [FIFO_DATA_W-1:0] pop_data,
   output logic                   pop_valid,
   output logic                   full,
   output logic                   empty,
   output logic [WIDTH:0]         count,
   output logic                   ovf,
   output logic                   udf,
   output logic                   WE_N,
   output logic                   RE_N,
   output logic [WIDTH-1:0]       W_ADR,
   output logic [WIDTH-1:0]       R_ADR,
   output logic [FIFO_DATA_W-1:0] DI,
   input  logic [FIFO_DATA_W-1:0] DO_0,
   input  logic [FIFO_DATA_W-1:0] DO_1
);
   logic [WIDTH:0]         wptr;
   logic [WIDTH:0]         rptr;
   logic [WIDTH:0]         vptr;
   logic                   push_ok;
   logic                   pop_ok;
   logic                   rbank;
   logic [FIFO_DATA_W-1:0] rd_mux;
   logic [FIFO_DATA_W-1:0] data_hold;

   assign full  = (wptr[WIDTH] != rptr[WIDTH]) && (wptr[WIDTH-1:0] == rptr[WIDTH-1:0]);
   // Readability trails wptr by a stage so a bank-conflict deferred write has landed.
   assign empty = (vptr == rptr);
   assign count = vptr - rptr;

   assign push_ok = push & ~full & ~rst;
   assign pop_ok  = pop & ~empty & ~rst;
   assign ovf     = push & full & ~rst;
   assign udf     = pop & empty & ~rst;

   assign WE_N  = push_ok;
   assign RE_N  = pop_ok;
   assign W_ADR = wptr[WIDTH-1:0];
   assign R_ADR = rptr[WIDTH-1:0];
   assign DI    = push_data;

   fifo_ptr #(.WIDTH(WIDTH)) u_wptr (
      .clk (clk),
      .rst (rst),
      .en  (push_ok),
      .ptr (wptr)
   );

   fifo_ptr #(.WIDTH(WIDTH)) u_rptr (
      .clk (clk),
      .rst (rst),
      .en  (pop_ok),
      .ptr (rptr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vptr      <= '0;
         rbank     <= 1'b0;
         pop_valid <= 1'b0;
         data_hold <= '0;
      end else begin
         vptr      <= wptr;
         pop_valid <= pop_ok;
         if (pop_ok)
            rbank <= R_ADR[MC_BANK_BIT];
         if (pop_valid)
            data_hold <= rd_mux;
      end
   end

   // SRAM data arrives the cycle after the strobe, so the return path is a live mux.
   assign rd_mux   = rbank ? DO_1 : DO_0;
   assign pop_data = pop_valid ? rd_mux : data_hold;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - directed self-checking bench for fifo_ptr_ctrl
module tb_fifo_ptr_ctrl;
   localparam int W = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [31:0]   push_data = '0;
   logic [31:0]   pop_data;
   logic          pop_valid, full, empty, ovf, udf, WE_N, RE_N;
   logic [W:0]    count;
   logic [W-1:0]  W_ADR, R_ADR;
   logic [31:0]   DI;
   logic [31:0]   DO_0 = '0;
   logic [31:0]   DO_1 = '0;
   logic [31:0]   mem [0:7];

   int n_checks = 0;
   int n_fail   = 0;
   int mw, mv, mr;
   logic [31:0] q [$];
   logic [31:0] pend;

   fifo_ptr_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
      .count(count), .ovf(ovf), .udf(udf), .WE_N(WE_N), .RE_N(RE_N),
      .W_ADR(W_ADR), .R_ADR(R_ADR), .DI(DI), .DO_0(DO_0), .DO_1(DO_1)
   );

   always #5 clk = ~clk;

   // Two SRAM banks selected by address LSB, one-cycle read latency.
   always @(posedge clk) begin
      if (WE_N) mem[W_ADR] <= DI;
      if (RE_N) begin
         if (R_ADR[0]) DO_1 <= mem[R_ADR];
         else          DO_0 <= mem[R_ADR];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic p, input logic [31:0] d, input logic o);
      @(negedge clk);
      push = p;
      push_data = d;
      pop = o;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      push = 1'b1;
      pop = 1'b1;
      #1;
      check("rst_we_gated", WE_N, 0);
      check("rst_re_gated", RE_N, 0);
      push = 1'b0;
      pop = 1'b0;
      @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_pop_valid", pop_valid, 0);
      check("rst_ovf_udf", {ovf, udf}, 0);
      check("rst_pop_data", pop_data, 0);
      rst = 1'b0;
      q.delete();
      mw = 0; mv = 0; mr = 0;
   endtask

   initial begin
      do_reset();

      // three pushes, visibility two cycles later
      step(1, 32'h11, 0);
      check("p1_wadr", W_ADR, 0); check("p1_we", WE_N, 1);
      check("p1_di", DI, 32'h11); check("p1_empty", empty, 1);
      step(1, 32'h22, 0);
      check("p2_wadr", W_ADR, 1); check("p2_empty", empty, 1);
      step(1, 32'h33, 0);
      check("p3_wadr", W_ADR, 2); check("p3_empty", empty, 0);
      step(0, 0, 0);
      check("p3_count_t1", count, 2);
      step(0, 0, 0);
      check("p3_count_t2", count, 3);

      // fill to eight, then overflow
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, 32'h100 + i, 0);
         check("fill_we", WE_N, 1);
         check("fill_wadr", W_ADR, i);
         check("fill_full", full, 0);
      end
      step(1, 32'h1FF, 0);
      check("ovf_full", full, 1);
      check("ovf_we", WE_N, 0);
      check("ovf_pulse", ovf, 1);
      check("ovf_count_lag", count, 7);
      step(0, 0, 0);
      check("ovf_clear", ovf, 0);
      check("ovf_count", count, 8);

      // drain back-to-back, then underflow
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1);
         check("drain_re", RE_N, 1);
         check("drain_radr", R_ADR, i);
         if (i > 0) begin
            check("drain_valid", pop_valid, 1);
            check("drain_data", pop_data, 32'h100 + i - 1);
         end
      end
      step(0, 0, 0);
      check("drain_last_valid", pop_valid, 1);
      check("drain_last_data", pop_data, 32'h107);
      check("drain_empty", empty, 1);
      check("drain_count", count, 0);
      step(0, 0, 1);
      check("udf_pulse", udf, 1);
      check("udf_re", RE_N, 0);
      check("udf_no_valid", pop_valid, 0);
      step(0, 0, 0);
      check("udf_clear", udf, 0);
      check("hold_data", pop_data, 32'h107);

      // steady state: four entries, push and pop every cycle
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h200 + i, 0);
         q.push_back(32'h200 + i);
         mv = mw; mw++;
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0);
         mv = mw;
      end
      for (int i = 0; i < 20; i++) begin
         step(1, 32'h300 + i, 1);
         check("ss_wadr", W_ADR, mw % 8);
         check("ss_radr", R_ADR, mr % 8);
         check("ss_count", count, (mv - mr) % 16);
         check("ss_strobes", {WE_N, RE_N}, 2'b11);
         check("ss_ovf_udf", {ovf, udf}, 0);
         if (i > 0) begin
            check("ss_valid", pop_valid, 1);
            check("ss_data", pop_data, pend);
         end
         pend = q.pop_front();
         q.push_back(32'h300 + i);
         mv = mw; mw++; mr++;
      end
      step(0, 0, 0);
      check("ss_last_data", pop_data, pend);
      check("ss_final_count", count, (mv - mr) % 16);

      // push then immediate pop before visibility
      do_reset();
      step(1, 32'hA5, 0);
      step(0, 0, 1);
      check("vis_udf", udf, 1);
      check("vis_re_blocked", RE_N, 0);
      step(0, 0, 1);
      check("vis_re", RE_N, 1);
      check("vis_radr", R_ADR, 0);
      step(0, 0, 0);
      check("vis_valid", pop_valid, 1);
      check("vis_data", pop_data, 32'hA5);

      // reset during a pop burst
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 32'h400 + i, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_re", RE_N, 0);
      @(negedge clk);
      pop = 1'b0;
      rst = 1'b0;
      step(0, 0, 0);
      check("mid_rst_valid", pop_valid, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_count", count, 0);
      step(1, 32'h55, 0);
      check("mid_rst_wadr", W_ADR, 0);
      check("mid_rst_we", WE_N, 1);
      step(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
